// File: rtl/uga_dyna_status_rx.sv
`default_nettype none
// ============================================================================
// Module      : uga_dyna_status_rx
// Description : Dynamixel 1.0 status packet receiver. Validates length,
//               checksum and servo ID, then presents decoded fields.
// Revision    : 1.0 - initial release
// ============================================================================
module uga_dyna_status_rx #(
    parameter int MAX_PARAM      = 6,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_data_ready,
    input  logic                               rx_enable,
    input  logic [7:0]                         expected_id,
    output logic                               sts_valid,
    output logic [7:0]                         sts_id,
    output logic [7:0]                         sts_length,
    output logic [7:0]                         sts_error,
    output logic [8*MAX_PARAM-1:0]             sts_param,
    output logic [$clog2(MAX_PARAM+1)-1:0]     sts_param_cnt,
    output logic                               csum_err,
    output logic                               len_err,
    output logic                               timeout_err,
    output logic                               busy
);

    localparam int                  c_PCNT_W   = $clog2(MAX_PARAM + 1);
    localparam int                  c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]          c_LEN_MAX  = 8'(MAX_PARAM + 2);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]          c_ANY_ID   = 8'hFE;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_HDR2  = 3'd1,
        RX_ID    = 3'd2,
        RX_LEN   = 3'd3,
        RX_ERR   = 3'd4,
        RX_PARAM = 3'd5,
        RX_CSUM  = 3'd6
    } rx_state_t;

    rx_state_t                r_state;
    rx_state_t                w_state_nxt;
    logic [7:0]               r_id;
    logic [7:0]               r_len;
    logic [7:0]               r_err;
    logic [7:0]               r_sum;
    logic [c_PCNT_W-1:0]      r_pcnt;
    logic [8*MAX_PARAM-1:0]   r_param;
    logic [c_TMO_W-1:0]       r_tmo_cnt;

    logic                     w_accept;
    logic                     w_tmo_hit;
    logic                     w_len_ok;
    logic [7:0]               w_sum_nxt;
    logic                     w_commit;
    logic                     w_csum_bad;
    logic                     w_len_bad;

    assign w_accept  = rx_data_ready & rx_enable;
    assign w_tmo_hit = (r_state != RX_IDLE) && !w_accept && (r_tmo_cnt == c_TMO_LAST);
    assign w_len_ok  = (rx_data >= 8'd2) && (rx_data <= c_LEN_MAX);
    assign w_sum_nxt = r_sum + rx_data;
    assign busy      = (r_state != RX_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_csum_bad  = 1'b0;
        w_len_bad   = 1'b0;
        if (w_accept) begin
            case (r_state)
                RX_IDLE:  if (rx_data == 8'hFF) w_state_nxt = RX_HDR2;
                RX_HDR2:  w_state_nxt = (rx_data == 8'hFF) ? RX_ID : RX_IDLE;
                RX_ID:    if (rx_data != 8'hFF) w_state_nxt = RX_LEN;
                RX_LEN: begin
                    if (w_len_ok) begin
                        w_state_nxt = RX_ERR;
                    end else begin
                        w_len_bad   = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end
                end
                RX_ERR:   w_state_nxt = (r_len == 8'd2) ? RX_CSUM : RX_PARAM;
                RX_PARAM: if (8'(r_pcnt) == r_len - 8'd3) w_state_nxt = RX_CSUM;
                RX_CSUM: begin
                    w_state_nxt = RX_IDLE;
                    if (rx_data == ~r_sum) begin
                        // Packets for other servos pass the checksum but are dropped silently
                        w_commit = (r_id == expected_id) || (expected_id == c_ANY_ID);
                    end else begin
                        w_csum_bad = 1'b1;
                    end
                end
                default:  w_state_nxt = RX_IDLE;
            endcase
        end else if (w_tmo_hit) begin
            w_state_nxt = RX_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RX_IDLE;
            r_id          <= '0;
            r_len         <= '0;
            r_err         <= '0;
            r_sum         <= '0;
            r_pcnt        <= '0;
            r_param       <= '0;
            r_tmo_cnt     <= '0;
            sts_valid     <= 1'b0;
            csum_err      <= 1'b0;
            len_err       <= 1'b0;
            timeout_err   <= 1'b0;
            sts_id        <= '0;
            sts_length    <= '0;
            sts_error     <= '0;
            sts_param     <= '0;
            sts_param_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            sts_valid   <= w_commit;
            csum_err    <= w_csum_bad;
            len_err     <= w_len_bad;
            timeout_err <= w_tmo_hit;

            if (r_state == RX_IDLE || w_accept) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end

            if (w_accept) begin
                case (r_state)
                    RX_ID: begin
                        if (rx_data != 8'hFF) begin
                            r_id  <= rx_data;
                            r_sum <= rx_data;
                        end
                    end
                    RX_LEN: begin
                        // Clearing here keeps bytes of a longer earlier packet out of sts_param
                        if (w_len_ok) begin
                            r_len   <= rx_data;
                            r_sum   <= w_sum_nxt;
                            r_param <= '0;
                        end
                    end
                    RX_ERR: begin
                        r_err  <= rx_data;
                        r_sum  <= w_sum_nxt;
                        r_pcnt <= '0;
                    end
                    RX_PARAM: begin
                        for (int k = 0; k < MAX_PARAM; k++) begin
                            if (r_pcnt == c_PCNT_W'(k)) r_param[8*k +: 8] <= rx_data;
                        end
                        r_sum  <= w_sum_nxt;
                        r_pcnt <= r_pcnt + c_PCNT_W'(1);
                    end
                    default: ;
                endcase
            end

            if (w_commit) begin
                sts_id        <= r_id;
                sts_length    <= r_len;
                sts_error     <= r_err;
                sts_param     <= r_param;
                sts_param_cnt <= c_PCNT_W'(r_len - 8'd2);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uga_dyna_status_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uga_dyna_status_rx
// Description : Self-checking bench for uga_dyna_status_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uga_dyna_status_rx;

    localparam int MAXP = 6;
    localparam int TMO  = 50000;
    localparam int STMO = 16;
    localparam int NB   = 80;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = '0;
    logic             rx_data_ready = 1'b0;
    logic             rx_enable = 1'b1;
    logic [7:0]       expected_id = 8'h02;

    logic             sts_valid, csum_err, len_err, timeout_err, busy;
    logic [7:0]       sts_id, sts_length, sts_error;
    logic [8*MAXP-1:0] sts_param;
    logic [2:0]       sts_param_cnt;

    logic             s_valid, s_csum, s_len, s_tmo, s_busy;
    logic [7:0]       s_id, s_length, s_err;
    logic [8*MAXP-1:0] s_param;
    logic [2:0]       s_cnt;

    always #5 clk = ~clk;

    uga_dyna_status_rx #(.MAX_PARAM(MAXP), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
        .rx_enable(rx_enable), .expected_id(expected_id),
        .sts_valid(sts_valid), .sts_id(sts_id), .sts_length(sts_length),
        .sts_error(sts_error), .sts_param(sts_param), .sts_param_cnt(sts_param_cnt),
        .csum_err(csum_err), .len_err(len_err), .timeout_err(timeout_err), .busy(busy)
    );

    // Short-timeout instance for the byte-versus-timeout boundary
    uga_dyna_status_rx #(.MAX_PARAM(MAXP), .TIMEOUT_CYCLES(STMO)) u_dut_s (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
        .rx_enable(rx_enable), .expected_id(expected_id),
        .sts_valid(s_valid), .sts_id(s_id), .sts_length(s_length),
        .sts_error(s_err), .sts_param(s_param), .sts_param_cnt(s_cnt),
        .csum_err(s_csum), .len_err(s_len), .timeout_err(s_tmo), .busy(s_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Packet-level reference: preamble count plus a queue of body bytes
    int          m_hdr  = 0;
    int          m_idle = 0;
    logic [7:0]  m_q[$];
    logic        e_valid, e_csum, e_len, e_tmo;
    logic [7:0]  e_id, e_length, e_err;
    logic [8*MAXP-1:0] e_param;
    logic [2:0]  e_cnt;

    function void model_drop();
        m_hdr  = 0;
        m_idle = 0;
        m_q.delete();
    endfunction

    function void model_step(input logic r, input logic rdy, input logic en,
                             input logic [7:0] d, input logic [7:0] eid);
        logic [7:0] s;
        e_valid = 1'b0; e_csum = 1'b0; e_len = 1'b0; e_tmo = 1'b0;
        if (r) begin
            model_drop();
            e_id = '0; e_length = '0; e_err = '0; e_param = '0; e_cnt = '0;
        end else if (rdy && en) begin
            m_idle = 0;
            if (m_q.size() == 0) begin
                if (m_hdr >= 2) begin
                    if (d != 8'hFF) m_q.push_back(d);
                end else begin
                    m_hdr = (d == 8'hFF) ? m_hdr + 1 : 0;
                end
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 2 && (d < 8'd2 || int'(d) > MAXP + 2)) begin
                    e_len = 1'b1;
                    model_drop();
                end else if (m_q.size() >= 4 && m_q.size() == int'(m_q[1]) + 2) begin
                    s = '0;
                    for (int i = 0; i < m_q.size() - 1; i++) s = s + m_q[i];
                    if (d == ~s) begin
                        if (m_q[0] == eid || eid == 8'hFE) begin
                            e_valid  = 1'b1;
                            e_id     = m_q[0];
                            e_length = m_q[1];
                            e_err    = m_q[2];
                            e_param  = '0;
                            for (int i = 3; i < m_q.size() - 1; i++) e_param[8*(i-3) +: 8] = m_q[i];
                            e_cnt    = 3'(m_q[1] - 8'd2);
                        end
                    end else begin
                        e_csum = 1'b1;
                    end
                    model_drop();
                end
            end
        end else if (m_hdr > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                e_tmo = 1'b1;
                model_drop();
            end
        end
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic en, input logic [7:0] d, input string tag);
        logic [NB-1:0] act, exp;
        rst = r; rx_data_ready = rdy; rx_enable = en; rx_data = d;
        model_step(r, rdy, en, d, expected_id);
        @(posedge clk);
        #1;
        act = {sts_valid, csum_err, len_err, timeout_err, busy,
               sts_id, sts_length, sts_error, sts_param, sts_param_cnt};
        exp = {e_valid, e_csum, e_len, e_tmo, (m_hdr > 0),
               e_id, e_length, e_err, e_param, e_cnt};
        n_chk++;
        if (act === exp) n_pass++;
        else if (n_chk - n_pass <= 20) $display("FAIL %s: got %h want %h", tag, act, exp);
        rx_data_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        cyc(1'b0, 1'b1, 1'b1, b, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b1, 8'h00, "idle");
    endtask

    typedef struct packed {
        logic [95:0] bytes;   // byte 0 in the top octet
        logic [4:0]  n;
        logic [7:0]  eid;
        logic [2:0]  flags;   // {sts_valid, csum_err, len_err}
        logic [7:0]  id;
        logic [7:0]  len;
        logic [7:0]  p0;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tv[9];

    function automatic vec_t mk(input logic [95:0] b, input int n, input logic [7:0] eid,
                                input logic [2:0] f, input logic [7:0] id, input logic [7:0] len,
                                input logic [7:0] p0, input logic [2:0] cnt);
        vec_t v;
        v.bytes = b; v.n = 5'(n); v.eid = eid; v.flags = f;
        v.id = id; v.len = len; v.p0 = p0; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [95:0] b;
        logic [7:0]  pk[$];
        logic [7:0]  s, cs, id;
        int          len, np, hit, cnt;
        logic        seen;

        tv[0] = mk({48'hFFFF020200FB, 48'h0},   6, 8'h02, 3'b100, 8'h02, 8'h02, 8'h00, 3'd0);
        tv[1] = mk({56'hFFFF02030020DA, 40'h0}, 7, 8'h02, 3'b100, 8'h02, 8'h03, 8'h20, 3'd1);
        tv[2] = mk({56'hFFFFFF020200FB, 40'h0}, 7, 8'h02, 3'b100, 8'h02, 8'h02, 8'h00, 3'd0);
        tv[3] = mk({48'hFFFF020200FA, 48'h0},   6, 8'h02, 3'b010, 8'h02, 8'h02, 8'h00, 3'd0);
        tv[4] = mk({32'hFFFF0209, 64'h0},       4, 8'h02, 3'b001, 8'h02, 8'h02, 8'h00, 3'd0);
        tv[5] = mk({48'hFFFF050200F8, 48'h0},   6, 8'h02, 3'b000, 8'h02, 8'h02, 8'h00, 3'd0);
        tv[6] = mk({48'hFFFF050200F8, 48'h0},   6, 8'hFE, 3'b100, 8'h05, 8'h02, 8'h00, 3'd0);
        tv[7] = mk(96'hFFFF0108041122334455668D, 12, 8'hFE, 3'b100, 8'h01, 8'h08, 8'h11, 3'd6);
        tv[8] = mk({32'hFFFF0201, 64'h0},       4, 8'h02, 3'b001, 8'h01, 8'h08, 8'h11, 3'd6);

        expected_id = 8'h02;
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 8'h00, "reset");
        check_eq("reset_busy", {31'h0, busy}, 32'h0);
        idle(2);

        for (int v = 0; v < 9; v++) begin
            expected_id = tv[v].eid;
            b = tv[v].bytes;
            for (int k = 0; k < int'(tv[v].n); k++) send(b[95-8*k -: 8], "vec_byte");
            check_eq("vec_flags", {29'h0, sts_valid, csum_err, len_err}, {29'h0, tv[v].flags});
            check_eq("vec_id",    {24'h0, sts_id},        {24'h0, tv[v].id});
            check_eq("vec_len",   {24'h0, sts_length},    {24'h0, tv[v].len});
            check_eq("vec_p0",    {24'h0, sts_param[7:0]}, {24'h0, tv[v].p0});
            check_eq("vec_cnt",   {29'h0, sts_param_cnt}, {29'h0, tv[v].cnt});
            idle(1);
            check_eq("vec_busy",  {31'h0, busy}, 32'h0);
        end

        // Reset mid-packet, then a clean packet
        expected_id = 8'h02;
        send(8'hFF, "rst_seq"); send(8'hFF, "rst_seq"); send(8'h02, "rst_seq"); send(8'h02, "rst_seq");
        cyc(1'b1, 1'b0, 1'b1, 8'h00, "rst_mid");
        check_eq("rst_mid_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_mid_id", {24'h0, sts_id}, 32'h0);
        send(8'hFF, "rst_seq"); send(8'hFF, "rst_seq"); send(8'h02, "rst_seq");
        send(8'h02, "rst_seq"); send(8'h00, "rst_seq"); send(8'hFB, "rst_seq");
        check_eq("rst_then_good", {31'h0, sts_valid}, 32'h1);

        // rx_enable low drops bytes mid-packet
        send(8'hFF, "en_seq"); send(8'hFF, "en_seq"); send(8'h02, "en_seq");
        send(8'h03, "en_seq"); send(8'h00, "en_seq");
        cyc(1'b0, 1'b1, 1'b0, 8'h55, "en_low"); cyc(1'b0, 1'b1, 1'b0, 8'hDA, "en_low");
        send(8'h20, "en_seq"); send(8'hDA, "en_seq");
        check_eq("en_low_valid", {31'h0, sts_valid}, 32'h1);
        check_eq("en_low_p0", {24'h0, sts_param[7:0]}, 32'h20);

        // Full-length inter-byte timeout
        send(8'hFF, "tmo_seq"); send(8'hFF, "tmo_seq"); send(8'h02, "tmo_seq");
        hit = 0;
        for (int i = 1; i <= TMO + 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00, "tmo_wait");
            if (timeout_err) begin hit = i; break; end
        end
        check_eq("tmo_cycles", hit, TMO);
        idle(1);
        check_eq("tmo_busy", {31'h0, busy}, 32'h0);
        send(8'hFF, "tmo_seq"); send(8'hFF, "tmo_seq"); send(8'h02, "tmo_seq");
        send(8'h02, "tmo_seq"); send(8'h00, "tmo_seq"); send(8'hFB, "tmo_seq");
        check_eq("tmo_then_good", {31'h0, sts_valid}, 32'h1);

        // Byte arriving in the timeout cycle wins (short instance)
        send(8'hFF, "bnd"); send(8'hFF, "bnd"); send(8'h02, "bnd");
        seen = 1'b0;
        for (int i = 1; i < STMO; i++) begin
            idle(1);
            seen = seen | s_tmo;
        end
        check_eq("bnd_no_early_tmo", {31'h0, seen}, 32'h0);
        send(8'h02, "bnd");
        check_eq("bnd_byte_wins", {30'h0, s_tmo, s_busy}, 32'h1);
        send(8'h00, "bnd"); send(8'hFB, "bnd");
        check_eq("bnd_valid", {31'h0, s_valid}, 32'h1);
        check_eq("bnd_fields", {s_csum, s_len, s_id, s_length, s_err, s_cnt} ^ 32'(s_param),
                 {2'b00, 8'h02, 8'h02, 8'h00, 3'd0});
        send(8'hFF, "bnd"); send(8'hFF, "bnd"); send(8'h02, "bnd");
        cnt = 0;
        for (int i = 1; i <= STMO + 3; i++) begin
            idle(1);
            if (s_tmo) begin cnt = i; break; end
        end
        check_eq("bnd_tmo_cycles", cnt, STMO);

        // Randomized packet stream against the reference model
        for (int p = 0; p < 300; p++) begin
            case ($urandom_range(0, 3))
                0:       expected_id = 8'h02;
                1:       expected_id = 8'hFE;
                2:       expected_id = 8'h05;
                default: expected_id = 8'($urandom);
            endcase
            pk.delete();
            if ($urandom_range(0, 7) == 0) pk.push_back(8'($urandom));
            pk.push_back(8'hFF); pk.push_back(8'hFF);
            if ($urandom_range(0, 5) == 0) pk.push_back(8'hFF);
            case ($urandom_range(0, 2))
                0:       id = 8'h02;
                1:       id = 8'h05;
                default: id = 8'($urandom_range(0, 254));
            endcase
            len = $urandom_range(0, 9);
            pk.push_back(id); pk.push_back(8'(len));
            s = id + 8'(len);
            np = (len >= 2) ? len - 2 : 0;
            for (int k = 0; k < np + 1; k++) begin
                cs = 8'($urandom);
                pk.push_back(cs);
                s = s + cs;
            end
            cs = ~s;
            if ($urandom_range(0, 4) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            pk.push_back(cs);
            if ($urandom_range(0, 19) == 0) void'(pk.pop_back());
            foreach (pk[k]) begin
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 1) == 0) cyc(1'b0, 1'b1, 1'b0, 8'($urandom), "rand_gap");
                    else cyc(1'b0, 1'b0, 1'b1, 8'($urandom), "rand_gap");
                end
                if ($urandom_range(0, 399) == 0) cyc(1'b1, 1'b0, 1'b1, 8'h00, "rand_rst");
                send(pk[k], "rand_byte");
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
